// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int WORD_W     = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0000;
  localparam logic [3:0]        HALT_OP_DEF   = 4'hF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [WORD_W-1:0] w);
    return w[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/decode controls in, imem address and IF/ID register out.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic              stall;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] imem_data;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] pc_plus1;
  logic [WORD_W-1:0] if_id_instr;
  logic [WORD_W-1:0] if_id_pc1;
  logic              if_id_valid;
  logic              halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, pc_plus1, if_id_instr, if_id_pc1, if_id_valid, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, pc_plus1, if_id_instr, if_id_pc1, if_id_valid, halted
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register; bubble overrides load, neither means hold.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc1,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc1,
  output logic              o_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instr <= NOP_INSTR;
      o_pc1   <= '0;
      o_valid <= 1'b0;
    end else if (i_bubble) begin
      o_instr <= NOP_INSTR;
      o_pc1   <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_instr <= i_instr;
      o_pc1   <= i_pc1;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALT FSM and IF/ID register.
// Optional perf counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [3:0]        HALT_OP   = HALT_OP_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0]  fetch_cnt,
  output logic [WORD_W-1:0]  stall_cnt
`endif
);

  // state | meaning
  // RUN   | fetching one instruction per unstalled cycle
  // HALT  | halt opcode seen; PC frozen, bubbles into IF/ID until a branch

  fetch_state_t      r_state;
  logic              r_halted;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc1;
  logic              w_is_halt_op;
  logic              w_load;
  logic              w_bubble;

  assign w_pc1        = r_pc + 16'd1;
  assign w_is_halt_op = (opcode_of(bus.imem_data) == HALT_OP);

  assign w_load   = !bus.branch_taken && !bus.stall && (r_state == RUN);
  assign w_bubble = bus.branch_taken || (!bus.stall && (r_state == HALT));

  assign bus.imem_addr = r_pc;
  assign bus.pc_plus1  = w_pc1;
  assign bus.halted    = r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
      r_pc     <= RESET_PC;
    end else if (bus.branch_taken) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
      r_pc     <= bus.branch_target;
    end else if (!bus.stall && (r_state == RUN)) begin
      // A halt word still enters IF/ID, but the PC stays on it
      if (w_is_halt_op) begin
        r_state  <= HALT;
        r_halted <= 1'b1;
      end else begin
        r_pc <= w_pc1;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_instr  (bus.imem_data),
    .i_pc1    (w_pc1),
    .o_instr  (bus.if_id_instr),
    .o_pc1    (bus.if_id_pc1),
    .o_valid  (bus.if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] r_fetch_cnt;
  logic [WORD_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load && (r_fetch_cnt != 16'hFFFF))
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (bus.stall && !bus.branch_taken && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: fetch, stall, branch, wrap, halt, async reset.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic              use_ovr;
  logic [WORD_W-1:0] ovr_data;

  fetch_stage_if bus_if ();

`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] fetch_cnt;
  logic [WORD_W-1:0] stall_cnt;
`endif

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word = address + 0x1000 unless overridden
  always_comb begin
    bus_if.imem_data = bus_if.imem_addr + 16'h1000;
    if (use_ovr) bus_if.imem_data = ovr_data;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    use_ovr = 1'b0;
    ovr_data = 16'h0000;
    bus_if.stall = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.branch_target = 16'h0000;

    tick();
    chk("rst_addr",  bus_if.imem_addr, 16'h0000);
    chk("rst_pc1o",  bus_if.pc_plus1, 16'h0001);
    chk("rst_instr", bus_if.if_id_instr, 16'h0000);
    chk("rst_ifpc1", bus_if.if_id_pc1, 16'h0000);
    chk("rst_valid", {15'd0, bus_if.if_id_valid}, 16'h0000);
    chk("rst_halt",  {15'd0, bus_if.halted}, 16'h0000);
    rst_n = 1'b1;

    // Free run
    tick();
    chk("run1_addr",  bus_if.imem_addr, 16'h0001);
    chk("run1_instr", bus_if.if_id_instr, 16'h1000);
    chk("run1_pc1",   bus_if.if_id_pc1, 16'h0001);
    chk("run1_valid", {15'd0, bus_if.if_id_valid}, 16'h0001);
    tick();
    chk("run2_addr",  bus_if.imem_addr, 16'h0002);
    chk("run2_instr", bus_if.if_id_instr, 16'h1001);
    chk("run2_pc1",   bus_if.if_id_pc1, 16'h0002);
    tick(); tick(); tick();
    chk("run5_addr",  bus_if.imem_addr, 16'h0005);
    chk("run5_instr", bus_if.if_id_instr, 16'h1004);

    // Stall three cycles at pc=5
    bus_if.stall = 1'b1;
    tick(); tick(); tick();
    chk("stall_addr",  bus_if.imem_addr, 16'h0005);
    chk("stall_instr", bus_if.if_id_instr, 16'h1004);
    chk("stall_pc1",   bus_if.if_id_pc1, 16'h0005);
    chk("stall_valid", {15'd0, bus_if.if_id_valid}, 16'h0001);
    bus_if.stall = 1'b0;
    tick();
    chk("resume_addr",  bus_if.imem_addr, 16'h0006);
    chk("resume_instr", bus_if.if_id_instr, 16'h1005);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 16'd3);
    chk("fetch_cnt", fetch_cnt, 16'd6);
`endif
    tick();
    chk("pc7_addr", bus_if.imem_addr, 16'h0007);

    // Branch wins over a simultaneous stall
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0040;
    bus_if.stall = 1'b1;
    tick();
    chk("br_addr",  bus_if.imem_addr, 16'h0040);
    chk("br_valid", {15'd0, bus_if.if_id_valid}, 16'h0000);
    chk("br_instr", bus_if.if_id_instr, 16'h0000);
    bus_if.branch_taken = 1'b0;
    bus_if.stall = 1'b0;
    tick();
    chk("br_next_addr",  bus_if.imem_addr, 16'h0041);
    chk("br_next_instr", bus_if.if_id_instr, 16'h1040);
    chk("br_next_pc1",   bus_if.if_id_pc1, 16'h0041);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt_br", stall_cnt, 16'd3);
`endif

    // PC wrap at 0xFFFF
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'hFFFF;
    tick();
    bus_if.branch_taken = 1'b0;
    chk("wrap_addr", bus_if.imem_addr, 16'hFFFF);
    chk("wrap_pc1o", bus_if.pc_plus1, 16'h0000);
    tick();
    chk("wrap_next",  bus_if.imem_addr, 16'h0000);
    chk("wrap_ifpc1", bus_if.if_id_pc1, 16'h0000);
    chk("wrap_instr", bus_if.if_id_instr, 16'h0FFF);

    // Halt at pc=9
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0009;
    tick();
    bus_if.branch_taken = 1'b0;
    use_ovr = 1'b1;
    ovr_data = 16'hF000;
    chk("h_addr", bus_if.imem_addr, 16'h0009);
    tick();
    chk("h_instr", bus_if.if_id_instr, 16'hF000);
    chk("h_valid", {15'd0, bus_if.if_id_valid}, 16'h0001);
    chk("h_addr1", bus_if.imem_addr, 16'h0009);
    chk("h_halt",  {15'd0, bus_if.halted}, 16'h0001);
    use_ovr = 1'b0;
    tick();
    chk("h2_addr",  bus_if.imem_addr, 16'h0009);
    chk("h2_valid", {15'd0, bus_if.if_id_valid}, 16'h0000);
    chk("h2_instr", bus_if.if_id_instr, 16'h0000);
    tick();
    chk("h3_addr", bus_if.imem_addr, 16'h0009);
    chk("h3_halt", {15'd0, bus_if.halted}, 16'h0001);
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0020;
    tick();
    bus_if.branch_taken = 1'b0;
    chk("unh_addr", bus_if.imem_addr, 16'h0020);
    chk("unh_halt", {15'd0, bus_if.halted}, 16'h0000);
    tick();
    chk("unh_next",  bus_if.imem_addr, 16'h0021);
    chk("unh_instr", bus_if.if_id_instr, 16'h1020);

    // Async reset between edges while halted at 0x33
    bus_if.branch_taken = 1'b1;
    bus_if.branch_target = 16'h0033;
    use_ovr = 1'b1;
    ovr_data = 16'hF000;
    tick();
    bus_if.branch_taken = 1'b0;
    tick();
    chk("pre_addr", bus_if.imem_addr, 16'h0033);
    chk("pre_halt", {15'd0, bus_if.halted}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_addr",  bus_if.imem_addr, 16'h0000);
    chk("ar_valid", {15'd0, bus_if.if_id_valid}, 16'h0000);
    chk("ar_halt",  {15'd0, bus_if.halted}, 16'h0000);
    chk("ar_instr", bus_if.if_id_instr, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("ar_fcnt", fetch_cnt, 16'd0);
`endif
    use_ovr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_addr",  bus_if.imem_addr, 16'h0001);
    chk("post_instr", bus_if.if_id_instr, 16'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
